seg_disp_sched: RTL and testbench

//  Time-shares the 8-digit serial 7-seg display among NUM_SRC game counters (score, coins, time, lives).

---
 rtl/seg_disp_sched_pkg.sv | 40 ++++
 rtl/seg_disp_sched_bcd_iter.sv | 71 +++++++
 rtl/seg_disp_sched.sv | 192 +++++++++++++++++++
 tb/tb_seg_disp_sched.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_sched_pkg.sv
// Shared types, widths and the 7-segment pattern table for the display scheduler.
package seg_disp_sched_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        StSelect,
        StConvert,
        StEncode,
        StShift,
        StCommit,
        StHold
    } state_e;

    localparam int unsigned BinW       = 32;
    localparam int unsigned BcdDigits  = 10;
    localparam int unsigned BcdW       = 4 * BcdDigits;
    localparam int unsigned ShowDigits = 8;
    localparam int unsigned FrameW     = 8 * ShowDigits;
    localparam logic [7:0]  SegBlank   = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}; dp always off
    function automatic logic [7:0] seg_pattern(input logic [3:0] digit);
        logic [7:0] pat;
        case (digit)
            4'd0:    pat = 8'hC0;
            4'd1:    pat = 8'hF9;
            4'd2:    pat = 8'hA4;
            4'd3:    pat = 8'hB0;
            4'd4:    pat = 8'h99;
            4'd5:    pat = 8'h92;
            4'd6:    pat = 8'h82;
            4'd7:    pat = 8'hF8;
            4'd8:    pat = 8'h80;
            4'd9:    pat = 8'h90;
            default: pat = SegBlank;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg_disp_sched_bcd_iter.sv
// Iterative binary-to-BCD converter: one shift-add-3 step per cycle, 32 steps per value.
module seg_disp_sched_bcd_iter
    import seg_disp_sched_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [BinW-1:0] bin_i,
    output logic            done_o,
    output logic [BcdW-1:0] bcd_o
);

    localparam int unsigned CntW = $clog2(BinW);

    logic [BinW-1:0] bin_q, bin_d;
    logic [BcdW-1:0] bcd_q, bcd_d, adj;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            run_q, run_d;

    // Add 3 to every digit >= 5 so the following left shift carries correctly
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < int'(BcdDigits); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Load on start, otherwise step until the last bit has been shifted in
    always_comb begin
        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start_i) begin
            bin_d = bin_i;
            bcd_d = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            bcd_d = {adj[BcdW-2:0], bin_q[BinW-1]};
            bin_d = {bin_q[BinW-2:0], 1'b0};
            if (cnt_q == CntW'(BinW - 1)) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Converter state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    // Done marks the cycle performing the final step; bcd_o is complete the cycle after
    assign done_o = run_q && (cnt_q == CntW'(BinW - 1));
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg_disp_sched.sv
// Time-shares the serial 8-digit 7-segment display among up to four game counters.
module seg_disp_sched
    import seg_disp_sched_pkg::*;
#(
    parameter int unsigned NUM_SRC      = 4,
    parameter int unsigned DWELL_CYCLES = 100_000_000,
    parameter int unsigned CLK_DIV      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [32*NUM_SRC-1:0] src_val_i,
    input  logic [NUM_SRC-1:0]    src_en_i,
    input  logic                  urgent_req_i,
    input  logic [1:0]            urgent_sel_i,
    output logic [1:0]            cur_src_o,
    output logic                  busy_o,
    output logic                  ovf_o,
    output logic                  seg_clk_o,
    output logic                  seg_do_o,
    output logic                  seg_pen_o,
    output logic                  seg_clr_o
);

    localparam int unsigned DivW   = $clog2(CLK_DIV);
    localparam int unsigned DwellW = $clog2(DWELL_CYCLES + 1);
    localparam int unsigned BitW   = $clog2(FrameW);

    state_e             state_q;
    logic [1:0]         cur_src_q, pick_q, urgent_sel_q;
    logic               urgent_q, blank_q, busy_q, ovf_q;
    logic               seg_clk_q, seg_do_q, seg_pen_q, seg_clr_q, half_q;
    logic [FrameW-1:0]  sh_q;
    logic [DivW-1:0]    div_q;
    logic [BitW-1:0]    bit_q;
    logic [DwellW-1:0]  dwell_q;

    logic [31:0]        vals [NUM_SRC];
    logic [1:0]         cand, rr_pick, sel_idx;
    logic               rr_found, urgent_ok, sel_blank;
    logic [31:0]        sel_val;
    logic               bcd_done;
    logic [BcdW-1:0]    bcd;
    logic [FrameW-1:0]  frame;
    logic [3:0]         digit;
    logic               lead;

    // Source pick: pending urgent wins, else next enabled index after cur_src, wrapping
    always_comb begin
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            vals[i] = src_val_i[32*i +: 32];
        end
        cand     = cur_src_q;
        rr_pick  = cur_src_q;
        rr_found = 1'b0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            cand = (cand == 2'(NUM_SRC - 1)) ? 2'd0 : cand + 2'd1;
            if (!rr_found && src_en_i[cand]) begin
                rr_pick  = cand;
                rr_found = 1'b1;
            end
        end
        urgent_ok = urgent_q && (32'(urgent_sel_q) < NUM_SRC);
        sel_idx   = urgent_ok ? urgent_sel_q : rr_pick;
        sel_blank = !urgent_ok && !rr_found;
        sel_val   = sel_blank ? 32'd0 : vals[sel_idx];
    end

    seg_disp_sched_bcd_iter u_bcd (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (state_q == StSelect),
        .bin_i   (sel_val),
        .done_o  (bcd_done),
        .bcd_o   (bcd)
    );

    // Segment frame from the low 8 BCD digits, blanking leading zeros above digit 0
    always_comb begin
        frame = '1;
        lead  = 1'b1;
        digit = 4'd0;
        for (int i = int'(ShowDigits) - 1; i >= 0; i--) begin
            digit = bcd[4*i +: 4];
            if (digit != 4'd0 || i == 0) begin
                lead = 1'b0;
            end
            if (!blank_q && !lead) begin
                frame[8*i +: 8] = seg_pattern(digit);
            end
        end
    end

    // Frame sequencer, serial shifter and dwell timer with registered board outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StSelect;
            cur_src_q    <= 2'd0;
            pick_q       <= 2'd0;
            urgent_q     <= 1'b0;
            urgent_sel_q <= 2'd0;
            blank_q      <= 1'b0;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
            seg_clk_q    <= 1'b1;
            seg_do_q     <= 1'b0;
            seg_pen_q    <= 1'b0;
            seg_clr_q    <= 1'b0;
            half_q       <= 1'b0;
            sh_q         <= '0;
            div_q        <= '0;
            bit_q        <= '0;
            dwell_q      <= '0;
        end else begin
            seg_clr_q <= 1'b1;
            case (state_q)
                StSelect: begin
                    urgent_q <= 1'b0;
                    pick_q   <= sel_blank ? cur_src_q : sel_idx;
                    blank_q  <= sel_blank;
                    busy_q   <= 1'b1;
                    state_q  <= StConvert;
                end
                StConvert: begin
                    if (bcd_done) begin
                        state_q <= StEncode;
                    end
                end
                StEncode: begin
                    ovf_q     <= (bcd[BcdW-1:32] != 8'd0);
                    sh_q      <= frame;
                    seg_do_q  <= frame[FrameW-1];
                    seg_clk_q <= 1'b0;
                    seg_pen_q <= 1'b0;
                    half_q    <= 1'b0;
                    div_q     <= '0;
                    bit_q     <= '0;
                    state_q   <= StShift;
                end
                StShift: begin
                    if (div_q == DivW'(CLK_DIV - 1)) begin
                        div_q <= '0;
                        if (!half_q) begin
                            seg_clk_q <= 1'b1;
                            half_q    <= 1'b1;
                        end else if (bit_q == BitW'(FrameW - 1)) begin
                            state_q <= StCommit;
                        end else begin
                            // Next bit changes together with the falling clock
                            bit_q     <= bit_q + 1'b1;
                            seg_clk_q <= 1'b0;
                            seg_do_q  <= sh_q[FrameW-2];
                            sh_q      <= {sh_q[FrameW-2:0], 1'b0};
                            half_q    <= 1'b0;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                StCommit: begin
                    seg_pen_q <= 1'b1;
                    cur_src_q <= pick_q;
                    busy_q    <= 1'b0;
                    dwell_q   <= '0;
                    state_q   <= StHold;
                end
                StHold: begin
                    // Counter spans 0..DWELL_CYCLES; a pending urgent cuts the hold short
                    if (urgent_q || dwell_q == DwellW'(DWELL_CYCLES)) begin
                        state_q <= StSelect;
                    end else begin
                        dwell_q <= dwell_q + 1'b1;
                    end
                end
                default: state_q <= StSelect;
            endcase
            // A new pulse always lands, even in the cycle that consumes the old one
            if (urgent_req_i) begin
                urgent_q     <= 1'b1;
                urgent_sel_q <= urgent_sel_i;
            end
        end
    end

    assign cur_src_o = cur_src_q;
    assign busy_o    = busy_q;
    assign ovf_o     = ovf_q;
    assign seg_clk_o = seg_clk_q;
    assign seg_do_o  = seg_do_q;
    assign seg_pen_o = seg_pen_q;
    assign seg_clr_o = seg_clr_q;

endmodule

// File: tb/tb_seg_disp_sched.sv
// Directed bench for seg_disp_sched: frames, rotation, urgent preemption, overflow, reset.
module tb_seg_disp_sched;

    localparam int unsigned Dwell = 100;
    localparam int unsigned Lat   = 1059;
    localparam int unsigned Gap   = Dwell + 1 + Lat;
    localparam int unsigned Limit = 3000;

    localparam logic [63:0] F1234   = 64'hFFFF_FFFF_F9A4_B099;
    localparam logic [63:0] F12345  = 64'hF9A4_B099_9282_F880;
    localparam logic [63:0] F1000   = 64'hFFFF_FFFF_F9C0_C0C0;
    localparam logic [63:0] FMax    = 64'h9099_9082_F8A4_9092;
    localparam logic [63:0] FZero   = 64'hFFFF_FFFF_FFFF_FFC0;
    localparam logic [63:0] FBlank  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] F70     = 64'hFFFF_FFFF_FFFF_F8C0;
    localparam logic [63:0] FNines  = 64'h9090_9090_9090_9090;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] src_val = '0;
    logic [3:0]   src_en = 4'b0000;
    logic         urgent_req = 1'b0;
    logic [1:0]   urgent_sel = 2'd0;
    logic [1:0]   cur_src;
    logic         busy, ovf, seg_clk, seg_do, seg_pen, seg_clr;

    int errors = 0;
    int checks = 0;
    int n;
    logic [63:0] cap = '0;
    int unsigned seen = 0;
    int unsigned base = 0;

    seg_disp_sched #(
        .NUM_SRC      (4),
        .DWELL_CYCLES (Dwell),
        .CLK_DIV      (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .src_val_i    (src_val),
        .src_en_i     (src_en),
        .urgent_req_i (urgent_req),
        .urgent_sel_i (urgent_sel),
        .cur_src_o    (cur_src),
        .busy_o       (busy),
        .ovf_o        (ovf),
        .seg_clk_o    (seg_clk),
        .seg_do_o     (seg_do),
        .seg_pen_o    (seg_pen),
        .seg_clr_o    (seg_clr)
    );

    always #5 clk = ~clk;

    // Display-side shift register: take seg_do on every seg_clk rise
    always @(posedge seg_clk) begin
        cap  = {cap[62:0], seg_do};
        seen = seen + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Wait for the next seg_pen rise; counts negedges, rebases the bit count at the fall
    task automatic wait_commit(output int cnt);
        logic dark;
        cnt  = 0;
        dark = (seg_pen === 1'b0);
        while (!(dark && seg_pen === 1'b1) && cnt < int'(Limit)) begin
            @(negedge clk);
            cnt++;
            if (!dark && seg_pen === 1'b0) begin
                dark = 1'b1;
                base = seen;
            end
        end
        check("commit_wait_bounded", 64'(cnt < int'(Limit)), 64'd1);
    endtask

    task automatic wait_dark();
        int cnt;
        cnt = 0;
        while (seg_pen !== 1'b0 && cnt < int'(Limit)) begin
            @(negedge clk);
            cnt++;
        end
        base = seen;
        check("dark_wait_bounded", 64'(cnt < int'(Limit)), 64'd1);
    endtask

    task automatic check_frame(input string tag, input logic [63:0] exp_frame,
                               input logic [1:0] exp_src, input logic exp_ovf);
        check({tag, "_frame"}, cap, exp_frame);
        check({tag, "_bits"}, 64'(seen - base), 64'd64);
        check({tag, "_cur_src"}, 64'(cur_src), 64'(exp_src));
        check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        // Reset values
        src_val[31:0]   = 32'd1234;
        src_val[63:32]  = 32'd12345678;
        src_val[95:64]  = 32'd1000;
        src_val[127:96] = 32'hFFFF_FFFF;
        src_en          = 4'b0001;
        repeat (3) @(negedge clk);
        check("rst_cur_src", 64'(cur_src), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_seg_clk", 64'(seg_clk), 64'd1);
        check("rst_seg_do", 64'(seg_do), 64'd0);
        check("rst_seg_pen", 64'(seg_pen), 64'd0);
        check("rst_seg_clr", 64'(seg_clr), 64'd0);

        // Test 1: single source 1234, first-frame latency
        rst  = 1'b0;
        base = seen;
        check("t1_clr_first_cycle", 64'(seg_clr), 64'd0);
        wait_commit(n);
        check("t1_latency", 64'(n), 64'(Lat));
        check_frame("t1", F1234, 2'd0, 1'b0);
        check("t1_seg_clr", 64'(seg_clr), 64'd1);

        // Test 2: rotation over 1011 after cur_src 0
        src_en = 4'b1011;
        wait_commit(n);
        check("t2a_gap", 64'(n), 64'(Gap));
        check_frame("t2a", F12345, 2'd1, 1'b0);
        wait_commit(n);
        check("t2b_gap", 64'(n), 64'(Gap));
        check_frame("t2b", FMax, 2'd3, 1'b1);
        wait_commit(n);
        check("t2c_gap", 64'(n), 64'(Gap));
        check_frame("t2c", F1234, 2'd0, 1'b0);

        // Test 3: urgent mid-shift of src 1; later pulse overrides the selector
        wait_dark();
        repeat (300) @(negedge clk);
        urgent_sel = 2'd3;
        urgent_req = 1'b1;
        @(negedge clk);
        urgent_req = 1'b0;
        repeat (10) @(negedge clk);
        urgent_sel = 2'd2;
        urgent_req = 1'b1;
        src_val[63:32] = 32'd5;
        @(negedge clk);
        urgent_req = 1'b0;
        wait_commit(n);
        check_frame("t3a", F12345, 2'd1, 1'b0);
        wait_commit(n);
        check("t3b_gap", 64'(n), 64'(1 + Lat));
        check_frame("t3b", F1000, 2'd2, 1'b0);
        wait_commit(n);
        check("t3c_gap", 64'(n), 64'(Gap));
        check_frame("t3c", FMax, 2'd3, 1'b1);

        // Test 4: zero and 100_000_000 (digit 0 only, overflow)
        src_en        = 4'b0001;
        src_val[31:0] = 32'd0;
        wait_commit(n);
        check("t4a_gap", 64'(n), 64'(Gap));
        check_frame("t4a", FZero, 2'd0, 1'b0);
        src_val[31:0] = 32'd100_000_000;
        wait_commit(n);
        check_frame("t4b", FZero, 2'd0, 1'b1);

        // Test 5: nothing enabled keeps cur_src and blanks the display
        src_en = 4'b0100;
        wait_commit(n);
        check_frame("t5a", F1000, 2'd2, 1'b0);
        src_en = 4'b0000;
        wait_commit(n);
        check("t5b_gap", 64'(n), 64'(Gap));
        check_frame("t5b", FBlank, 2'd2, 1'b0);
        wait_commit(n);
        check("t5c_gap", 64'(n), 64'(Gap));
        check_frame("t5c", FBlank, 2'd2, 1'b0);

        // Test 6: reset during bit 30 of a src 0 frame
        src_en         = 4'b0101;
        src_val[95:64] = 32'd70;
        src_val[31:0]  = 32'd99_999_999;
        wait_dark();
        n = 0;
        while (64'(seen - base) != 64'd30 && n < int'(Limit)) begin
            @(negedge clk);
            n++;
        end
        check("t6_reach_bit30", 64'(seen - base), 64'd30);
        repeat (9) @(negedge clk);
        check("t6_clk_low_before_rst", 64'(seg_clk), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_seg_pen", 64'(seg_pen), 64'd0);
        check("t6_rst_seg_clk", 64'(seg_clk), 64'd1);
        check("t6_rst_seg_clr", 64'(seg_clr), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_cur_src", 64'(cur_src), 64'd0);
        rst  = 1'b0;
        base = seen;
        wait_commit(n);
        check("t6a_latency", 64'(n), 64'(Lat));
        check_frame("t6a", F70, 2'd2, 1'b0);
        wait_commit(n);
        check("t6b_gap", 64'(n), 64'(Gap));
        check_frame("t6b", FNines, 2'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
